div_issue: RTL and testbench
============================

# div_issue

EX-stage divide sequencer sitting directly upstream of the iterative divider and downstream of the ID/EX pipeline register. It decodes DIV/DIVU from the EX operation code, latches the operands, and drives the divider's start/signed/annul handshake. It holds the pipeline stalled for the divide's full duration, then presents the 64-bit result as a one-cycle HI/LO write toward MEM. A pipeline flush mid-divide cancels the operation cleanly.

## Interface
- No parameters; widths come from the shared defines (RegBus = 32, DoubleRegBus = 64, AluOpBus = 8).
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- aluop_i  in  8  EX operation code; EXE_DIV_OP / EXE_DIVU_OP trigger a divide
- reg1_i  in  32  dividend
- reg2_i  in  32  divisor
- flush_i  in  1  pipeline flush/exception; cancels any divide in progress
- div_result_i  in  64  divider result, {remainder, quotient}
- div_ready_i  in  1  divider result valid
- div_opdata1_o  out  32  latched dividend to divider
- div_opdata2_o  out  32  latched divisor to divider
- div_start_o  out  1  DivStart/DivStop to divider
- div_signed_o  out  1  1 = signed divide
- div_annul_o  out  1  cancel to divider
- stallreq_o  out  1  EX stall request to pipeline control (combinational)
- whilo_o  out  1  HI/LO write enable, one-cycle pulse
- hi_o  out  32  remainder
- lo_o  out  32  quotient

## Operation
- States: IDLE, WAIT, DONE. Reset: state IDLE. All registered outputs are 0: div_start_o = DivStop, div_annul_o = 0, whilo_o = 0, hi_o = lo_o = 0, operand registers = 0, div_signed_o = 0.
- IDLE:
  - div op and !flush_i: latch reg1_i/reg2_i into div_opdata*_o; div_signed_o = (aluop_i == EXE_DIV_OP); div_start_o <= DivStart; go to WAIT.
  - Otherwise stay in IDLE; whilo_o <= 0.
- WAIT:
  - Operands, div_signed_o and div_start_o are held constant.
  - flush_i: div_start_o <= DivStop; div_annul_o <= 1 for one cycle; go to IDLE; no HI/LO write.
  - Else div_ready_i: capture hi_o <= div_result_i[63:32], lo_o <= div_result_i[31:0]; whilo_o <= 1; div_start_o <= DivStop; go to DONE.
  - flush_i and div_ready_i in the same cycle: flush wins, no write.
- DONE: whilo_o is valid for exactly this cycle. Next state is IDLE and whilo_o <= 0. A div op on aluop_i is ignored here because it belongs to the instruction now retiring. flush_i in DONE does not suppress the write; the write is already committed.
- stallreq_o = (IDLE && div op && !flush_i) || WAIT. It is 0 in DONE.
- Result signs and the divide-by-zero value are the divider's responsibility; this block passes them through unchanged.
- Reset mid-operation: return to IDLE at the next edge. div_start_o drops to DivStop, which returns the divider to free.

## Timing
- Cycle T: IDLE with a div op; stallreq_o = 1 combinationally.
- T+1: div_start_o = 1.
- Divider asserts div_ready_i at some cycle R (≈ T+35 for a nonzero divisor).
- R+1: DONE; whilo_o = 1, stallreq_o = 0; the pipeline advances at the end of R+1.
- R+2: IDLE. A back-to-back div is accepted in R+2, giving a minimum of 1 non-stalled cycle between divides.
- div_annul_o is a single-cycle pulse. div_start_o deasserts on the same edge, so the divider sees annul or DivStop in any state.

## Configuration
- DIV_ZERO_FAST_EN defined:
  - In IDLE, a div op with reg2_i == 0 does not start the divider.
  - Go directly to DONE with hi_o = lo_o = 0 and whilo_o = 1.
  - stallreq_o is 1 for cycle T only.
- DIV_ZERO_FAST_EN undefined: a zero divisor follows the normal WAIT path; the divider returns 0.

## Structure
- Shared defines file holds:
  - EXE_DIV_OP, EXE_DIVU_OP
  - DivStart, DivStop
  - RegBus, DoubleRegBus, AluOpBus
  - the new state encodings DivIssueIdle, DivIssueWait, DivIssueDone (2 bits)
- No sub-module. The divider is instantiated alongside this block at the EX top level, not inside it.

## Test plan
- DIVU 100 / 7: stall through WAIT, then one whilo_o pulse with hi_o = 0x00000002, lo_o = 0x0000000E; stallreq_o falls in DONE.
- DIV 0xFFFFFFF9 (-7) / 2: div_signed_o = 1; lo_o = 0xFFFFFFFD, hi_o = 0xFFFFFFFF.
- Divisor 0:
  - Macro on: DONE at T+1, hi_o = lo_o = 0, div_start_o never rises.
  - Macro off: full WAIT path, result 0.
- flush_i 10 cycles into WAIT: one div_annul_o pulse, div_start_o = 0, no whilo_o, back in IDLE.
- div_ready_i and flush_i in the same cycle: no whilo_o. Separately, rst = 0 mid-WAIT: all outputs 0 the next cycle.
- Two consecutive DIVUs (0xFFFFFFFF / 0x10, then 9 / 3): two separate whilo_o pulses with {0xF, 0x0FFFFFFF} then {0, 3}; the second start rises only after IDLE.

Source files
------------

// File: rtl/div_issue_pkg.sv
// div_issue_pkg
// Shared definitions for the EX-stage divide sequencer:
//   - bus widths (RegBus, DoubleRegBus, AluOpBus)
//   - divide operation codes (EXE_DIV_OP, EXE_DIVU_OP)
//   - divider start/stop levels (DivStart, DivStop)
//   - sequencer state encodings (DivIssueIdle, DivIssueWait, DivIssueDone)
package div_issue_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;
    localparam int AluOpBus     = 8;

    localparam logic [AluOpBus-1:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [AluOpBus-1:0] EXE_DIVU_OP = 8'b0001_1011;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    typedef enum logic [1:0] {
        DivIssueIdle = 2'b00,
        DivIssueWait = 2'b01,
        DivIssueDone = 2'b10
    } div_issue_state_t;

    function automatic logic is_div_op(input logic [AluOpBus-1:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_issue.sv
// div_issue
// EX-stage divide sequencer. Decodes DIV/DIVU, latches the operands, drives
// the iterative divider's start/signed/annul handshake, stalls the pipeline
// while the divide runs and presents the result as a one-cycle HI/LO write.
//
// Optional build feature: define DIV_ZERO_FAST_EN to skip the divider for a
// zero divisor and complete in one cycle with a zero result.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous reset, active low
//   aluop_i        EX operation code
//   reg1_i/reg2_i  dividend / divisor from ID/EX
//   flush_i        pipeline flush, cancels a divide in progress
//   div_result_i   divider result {remainder, quotient}
//   div_ready_i    divider result valid
//   div_opdata1_o  latched dividend to divider
//   div_opdata2_o  latched divisor to divider
//   div_start_o    DivStart/DivStop level to divider
//   div_signed_o   1 = signed divide
//   div_annul_o    single-cycle cancel pulse to divider
//   stallreq_o     EX stall request (combinational)
//   whilo_o        HI/LO write enable, one-cycle pulse
//   hi_o / lo_o    remainder / quotient
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no divide in flight; accepts a new DIV/DIVU
// WAIT  | divider running; operands held, pipeline stalled
// DONE  | result on hi_o/lo_o, whilo_o high for this one cycle
module div_issue
    import div_issue_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [AluOpBus-1:0]     aluop_i,
    input  logic [RegBus-1:0]       reg1_i,
    input  logic [RegBus-1:0]       reg2_i,
    input  logic                    flush_i,
    input  logic [DoubleRegBus-1:0] div_result_i,
    input  logic                    div_ready_i,
    output logic [RegBus-1:0]       div_opdata1_o,
    output logic [RegBus-1:0]       div_opdata2_o,
    output logic                    div_start_o,
    output logic                    div_signed_o,
    output logic                    div_annul_o,
    output logic                    stallreq_o,
    output logic                    whilo_o,
    output logic [RegBus-1:0]       hi_o,
    output logic [RegBus-1:0]       lo_o
);

    div_issue_state_t state, state_nxt;

    logic [RegBus-1:0] opdata1_nxt, opdata2_nxt;
    logic [RegBus-1:0] hi_nxt, lo_nxt;
    logic              start_nxt, signed_nxt, annul_nxt, whilo_nxt;
    logic              div_op;

    assign div_op = is_div_op(aluop_i);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= DivIssueIdle;
            div_opdata1_o <= '0;
            div_opdata2_o <= '0;
            div_start_o   <= DivStop;
            div_signed_o  <= 1'b0;
            div_annul_o   <= 1'b0;
            whilo_o       <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
        end else begin
            state         <= state_nxt;
            div_opdata1_o <= opdata1_nxt;
            div_opdata2_o <= opdata2_nxt;
            div_start_o   <= start_nxt;
            div_signed_o  <= signed_nxt;
            div_annul_o   <= annul_nxt;
            whilo_o       <= whilo_nxt;
            hi_o          <= hi_nxt;
            lo_o          <= lo_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        opdata1_nxt = div_opdata1_o;
        opdata2_nxt = div_opdata2_o;
        start_nxt   = div_start_o;
        signed_nxt  = div_signed_o;
        annul_nxt   = 1'b0;
        whilo_nxt   = 1'b0;
        hi_nxt      = hi_o;
        lo_nxt      = lo_o;

        case (state)
            DivIssueIdle: begin
                start_nxt = DivStop;
                if (div_op && !flush_i) begin
`ifdef DIV_ZERO_FAST_EN
                    if (reg2_i == '0) begin
                        // Zero divisor: the divider is never started.
                        hi_nxt    = '0;
                        lo_nxt    = '0;
                        whilo_nxt = 1'b1;
                        state_nxt = DivIssueDone;
                    end else begin
                        opdata1_nxt = reg1_i;
                        opdata2_nxt = reg2_i;
                        signed_nxt  = (aluop_i == EXE_DIV_OP);
                        start_nxt   = DivStart;
                        state_nxt   = DivIssueWait;
                    end
`else
                    opdata1_nxt = reg1_i;
                    opdata2_nxt = reg2_i;
                    signed_nxt  = (aluop_i == EXE_DIV_OP);
                    start_nxt   = DivStart;
                    state_nxt   = DivIssueWait;
`endif
                end
            end

            DivIssueWait: begin
                // Flush has priority over a result arriving the same cycle.
                if (flush_i) begin
                    start_nxt = DivStop;
                    annul_nxt = 1'b1;
                    state_nxt = DivIssueIdle;
                end else if (div_ready_i) begin
                    hi_nxt    = div_result_i[DoubleRegBus-1:RegBus];
                    lo_nxt    = div_result_i[RegBus-1:0];
                    whilo_nxt = 1'b1;
                    start_nxt = DivStop;
                    state_nxt = DivIssueDone;
                end
            end

            DivIssueDone: begin
                // A div op seen here belongs to the retiring instruction.
                start_nxt = DivStop;
                state_nxt = DivIssueIdle;
            end

            default: begin
                start_nxt = DivStop;
                state_nxt = DivIssueIdle;
            end
        endcase
    end

    assign stallreq_o = ((state == DivIssueIdle) && div_op && !flush_i) ||
                        (state == DivIssueWait);

endmodule

// File: tb/tb_div_issue.sv
module tb_div_issue;
    import div_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [31:0] reg1_i, reg2_i;
    logic        flush_i;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o, div_opdata2_o;
    logic        div_start_o, div_signed_o, div_annul_o, stallreq_o, whilo_o;
    logic [31:0] hi_o, lo_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] exp_q[$];

    div_issue dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop_i),
        .reg1_i       (reg1_i),
        .reg2_i       (reg2_i),
        .flush_i      (flush_i),
        .div_result_i (div_result_i),
        .div_ready_i  (div_ready_i),
        .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o),
        .div_start_o  (div_start_o),
        .div_signed_o (div_signed_o),
        .div_annul_o  (div_annul_o),
        .stallreq_o   (stallreq_o),
        .whilo_o      (whilo_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference divide: {remainder, quotient}, truncating toward zero.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        if (b == 32'd0) return 64'd0;
        if (!sgn) return {a % b, a / b};
        sa = $signed(a);
        sb = $signed(b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Scoreboard monitor: every HI/LO write must match the oldest expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (whilo_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_whilo", 64'd1, 64'd0);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("hi_o", {32'd0, hi_o}, {32'd0, e[63:32]});
                    chk("lo_o", {32'd0, lo_o}, {32'd0, e[31:0]});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            aluop_i = 8'd0; flush_i = 1'b0; div_ready_i = 1'b0;
            @(negedge clk);
            chk("idle_stall", {63'd0, stallreq_o}, 64'd0);
        end
    endtask

    // mode: 0 normal, 1 flush mid-WAIT, 2 flush together with ready, 3 reset mid-WAIT
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input int lat, input int mode);
        logic [63:0] exp;
        bit fast;
        bit stop;
        exp  = ref_div(op == EXE_DIV_OP, a, b);
        fast = 1'b0;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'd0) fast = 1'b1;
`endif
        @(posedge clk); #1;
        aluop_i = op; reg1_i = a; reg2_i = b; flush_i = 1'b0; div_ready_i = 1'b0;
        if (mode == 0) exp_q.push_back(exp);
        @(negedge clk);
        chk("issue_stall", {63'd0, stallreq_o}, 64'd1);
        chk("issue_start", {63'd0, div_start_o}, 64'd0);
        if (fast) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("fast_done_stall", {63'd0, stallreq_o}, 64'd0);
            chk("fast_done_start", {63'd0, div_start_o}, 64'd0);
            return;
        end
        stop = 1'b0;
        for (int k = 1; k <= lat && !stop; k++) begin
            @(posedge clk); #1;
            if (k == lat && (mode == 0 || mode == 2)) begin
                // Divider model works from the operands the DUT latched.
                div_ready_i  = 1'b1;
                div_result_i = ref_div(div_signed_o, div_opdata1_o, div_opdata2_o);
                if (mode == 2) begin flush_i = 1'b1; stop = 1'b1; end
            end
            if (mode == 1 && k == 10) begin flush_i = 1'b1; stop = 1'b1; end
            if (mode == 3 && k == 5) begin rst = 1'b0; stop = 1'b1; end
            @(negedge clk);
            chk("wait_start", {63'd0, div_start_o}, 64'd1);
            chk("wait_stall", {63'd0, stallreq_o}, 64'd1);
            chk("wait_signed", {63'd0, div_signed_o}, {63'd0, op == EXE_DIV_OP});
            chk("wait_opdata1", {32'd0, div_opdata1_o}, {32'd0, a});
            chk("wait_opdata2", {32'd0, div_opdata2_o}, {32'd0, b});
        end
        @(posedge clk); #1;
        div_ready_i = 1'b0; flush_i = 1'b0; rst = 1'b1;
        if (mode != 0) aluop_i = 8'd0;
        @(negedge clk);
        case (mode)
            0: begin
                chk("done_stall", {63'd0, stallreq_o}, 64'd0);
                chk("done_start", {63'd0, div_start_o}, 64'd0);
                chk("done_whilo", {63'd0, whilo_o}, 64'd1);
            end
            1, 2: begin
                chk("flush_annul", {63'd0, div_annul_o}, 64'd1);
                chk("flush_start", {63'd0, div_start_o}, 64'd0);
                chk("flush_whilo", {63'd0, whilo_o}, 64'd0);
                chk("flush_stall", {63'd0, stallreq_o}, 64'd0);
                @(posedge clk); #1;
                @(negedge clk);
                chk("annul_pulse_end", {63'd0, div_annul_o}, 64'd0);
                chk("flush_no_whilo", {63'd0, whilo_o}, 64'd0);
            end
            default: begin
                chk("rst_start", {63'd0, div_start_o}, 64'd0);
                chk("rst_annul", {63'd0, div_annul_o}, 64'd0);
                chk("rst_whilo", {63'd0, whilo_o}, 64'd0);
                chk("rst_signed", {63'd0, div_signed_o}, 64'd0);
                chk("rst_hilo", {hi_o, lo_o}, 64'd0);
                chk("rst_opdata", {div_opdata1_o, div_opdata2_o}, 64'd0);
                chk("rst_stall", {63'd0, stallreq_o}, 64'd0);
            end
        endcase
    endtask

    initial begin
        rst = 1'b0; aluop_i = 8'd0; reg1_i = 32'd0; reg2_i = 32'd0;
        flush_i = 1'b0; div_result_i = 64'd0; div_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_start", {63'd0, div_start_o}, 64'd0);
        chk("reset_annul", {63'd0, div_annul_o}, 64'd0);
        chk("reset_whilo", {63'd0, whilo_o}, 64'd0);
        chk("reset_signed", {63'd0, div_signed_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        chk("reset_opdata", {div_opdata1_o, div_opdata2_o}, 64'd0);
        chk("reset_stall", {63'd0, stallreq_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        run_div(EXE_DIVU_OP, 32'd100, 32'd7, 34, 0);
        run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 20, 0);
        run_div(EXE_DIVU_OP, 32'd5, 32'd0, 35, 0);
        run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h10, 12, 0);
        run_div(EXE_DIVU_OP, 32'd9, 32'd3, 6, 0);
        idle(1);
        run_div(EXE_DIV_OP, 32'd1000, 32'd3, 30, 1);
        run_div(EXE_DIVU_OP, 32'd77, 32'd5, 8, 2);
        run_div(EXE_DIVU_OP, 32'd123456, 32'd789, 25, 3);
        idle(1);

        for (int i = 0; i < 12; i++) begin
            logic [7:0]  op;
            logic [31:0] a, b;
            op = ($urandom_range(0, 1) == 1) ? EXE_DIV_OP : EXE_DIVU_OP;
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom >> $urandom_range(0, 28));
            run_div(op, a, b, $urandom_range(2, 40), 0);
            idle($urandom_range(0, 2));
        end

        idle(3);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
